// File: rtl/snake_pkg.sv
// Shared constants, state encoding and length clamp for the snake collision scanner.
// The optional wall check (SNAKE_WALL_HIT_EN) uses SCREEN_W / SCREEN_H from here.
package snake_pkg;

  localparam int SEG_W    = 10;
  localparam int MAX_SEGS = 100;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int IDX_W    = 7;
  localparam int BUS_W    = SEG_W * MAX_SEGS;

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(MAX_SEGS - 1);
  localparam logic [SEG_W-1:0] WALL_X    = SEG_W'(SCREEN_W);
  localparam logic [SEG_W-1:0] WALL_Y    = SEG_W'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } scan_state_e;

  // Body length saturates at the last slot of the packed bus.
  function automatic logic [IDX_W-1:0] clamp_len(input logic [9:0] len);
    if (len > 10'(MAX_SEGS - 1)) begin
      return LAST_SLOT;
    end else begin
      return len[IDX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/snake_seg_select.sv
// Combinational slot mux: picks slot idx (X and Y) out of the packed snapshot buses.
module snake_seg_select
  import snake_pkg::*;
(
  input  logic [BUS_W-1:0] bus_x,
  input  logic [BUS_W-1:0] bus_y,
  input  logic [IDX_W-1:0] idx,
  output logic [SEG_W-1:0] seg_x,
  output logic [SEG_W-1:0] seg_y
);

  // Out-of-range indices yield zero; the scanner never issues them.
  always_comb begin
    seg_x = '0;
    seg_y = '0;
    for (int i = 0; i < MAX_SEGS; i++) begin
      if (idx == IDX_W'(i)) begin
        seg_x = bus_x[i*SEG_W +: SEG_W];
        seg_y = bus_y[i*SEG_W +: SEG_W];
      end
    end
  end

endmodule

// File: rtl/snake_collision_scanner.sv
// Per-tick collision scanner: walks body slots 1..len against the head, checks head vs food.
// Optional SNAKE_WALL_HIT_EN adds a wall_hit output that also forces self_hit.
module snake_collision_scanner
  import snake_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic [BUS_W-1:0]   pos_x,
  input  logic [BUS_W-1:0]   pos_y,
  input  logic [9:0]         length,
  input  logic [SEG_W-1:0]   food_x,
  input  logic [SEG_W-1:0]   food_y,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               self_hit,
  output logic               food_hit,
`ifdef SNAKE_WALL_HIT_EN
  output logic               wall_hit,
`endif
  output scan_state_e        state
);

  // Handshake: start is sampled only in IDLE; busy covers SCAN and DONE; done pulses
  // for one cycle and the flags stay valid until the next accepted start.

  logic [BUS_W-1:0] snap_x;
  logic [BUS_W-1:0] snap_y;
  logic [IDX_W-1:0] len_snap;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] len_now;
  logic [SEG_W-1:0] seg_x;
  logic [SEG_W-1:0] seg_y;
  logic             food_now;
  logic             seg_match;
  logic             wall_now;

  snake_seg_select u_seg_select (
    .bus_x (snap_x),
    .bus_y (snap_y),
    .idx   (idx),
    .seg_x (seg_x),
    .seg_y (seg_y)
  );

  assign len_now   = clamp_len(length);
  assign food_now  = (pos_x[SEG_W-1:0] == food_x) && (pos_y[SEG_W-1:0] == food_y);
  assign seg_match = (seg_x == snap_x[SEG_W-1:0]) && (seg_y == snap_y[SEG_W-1:0]);

`ifdef SNAKE_WALL_HIT_EN
  assign wall_now = (pos_x[SEG_W-1:0] >= WALL_X) || (pos_y[SEG_W-1:0] >= WALL_Y);
`else
  assign wall_now = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      self_hit <= 1'b0;
      food_hit <= 1'b0;
      idx      <= '0;
      len_snap <= '0;
      snap_x   <= '0;
      snap_y   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap_x   <= pos_x;
            snap_y   <= pos_y;
            len_snap <= len_now;
            self_hit <= wall_now;
            food_hit <= food_now;
            idx      <= IDX_W'(1);
            busy     <= 1'b1;
            if (len_now == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SCAN;
            end
          end
        end
        S_SCAN: begin
          // Sticky flag with no early exit keeps latency fixed at len_snap cycles.
          if (seg_match) begin
            self_hit <= 1'b1;
          end
          if (idx == len_snap) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SNAKE_WALL_HIT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wall_hit <= 1'b0;
    end else if (state == S_IDLE && start) begin
      wall_hit <= wall_now;
    end
  end
`endif

endmodule

// File: tb/tb_snake_collision_scanner.sv
// Bench for snake_collision_scanner: vector table plus reset, held-start and wall sequences.
module tb_snake_collision_scanner;
  import snake_pkg::*;

  logic             clock = 1'b0;
  logic             reset;
  logic [BUS_W-1:0] pos_x;
  logic [BUS_W-1:0] pos_y;
  logic [9:0]       length;
  logic [SEG_W-1:0] food_x;
  logic [SEG_W-1:0] food_y;
  logic             start;
  logic             busy;
  logic             done;
  logic             self_hit;
  logic             food_hit;
`ifdef SNAKE_WALL_HIT_EN
  logic             wall_hit;
`endif
  scan_state_e      state;

  int checks   = 0;
  int failures = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    int len;
    int hx;
    int hy;
    int fx;
    int fy;
    int mslot;
    int mmode;
    int lat;
    bit eself;
    bit efood;
  } vec_t;

  vec_t vecs[10];

  snake_collision_scanner dut (
    .clock    (clock),
    .reset    (reset),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .length   (length),
    .food_x   (food_x),
    .food_y   (food_y),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .self_hit (self_hit),
    .food_hit (food_hit),
`ifdef SNAKE_WALL_HIT_EN
    .wall_hit (wall_hit),
`endif
    .state    (state)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_slot(input int i, input int x, input int y);
    pos_x[i*SEG_W +: SEG_W] = SEG_W'(x);
    pos_y[i*SEG_W +: SEG_W] = SEG_W'(y);
  endtask

  task automatic fill_body();
    for (int i = 1; i < MAX_SEGS; i++) set_slot(i, 700 + i, 900 - i);
  endtask

  task automatic sb_pop(input string tag);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s_sb: got done expected no done", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_self"}, 32'(self_hit), 32'(e[1]));
      chk({tag, "_food"}, 32'(food_hit), 32'(e[0]));
    end
  endtask

  // Called right after the start edge; drops start and waits for done.
  task automatic wait_done(input int exp_lat, input string tag);
    int  c;
    bit  seen;
    seen = 1'b0;
    for (c = 0; c < 150; c++) begin
      @(negedge clock);
      start = 1'b0;
      if (c == 0 && exp_lat > 0) chk({tag, "_busy"}, 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_lat"}, seen ? 32'(c) : 32'hFFFF_FFFF, 32'(exp_lat));
    if (seen) begin
      sb_pop(tag);
      @(negedge clock);
      chk({tag, "_pulse"}, 32'(done), 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    fill_body();
    set_slot(0, v.hx, v.hy);
    if (v.mmode == 1) set_slot(v.mslot, v.hx, v.hy);
    if (v.mmode == 2) set_slot(v.mslot, v.hx, v.hy + 1);
    length = 10'(v.len);
    food_x = SEG_W'(v.fx);
    food_y = SEG_W'(v.fy);
    start  = 1'b1;
    exp_q.push_back({v.eself, v.efood});
    @(posedge clock);
    wait_done(v.lat, tag);
  endtask

  initial begin
    int ndone;
    int first_at;
    int second_at;

    //            len  hx    hy    fx    fy   mslot mode lat self food
    vecs[0] = '{  0,  320,  240,  320,  240,   0,  0,   0, 0, 1};
    vecs[1] = '{  5,  100,  100,    1,    1,   5,  1,   5, 1, 0};
    vecs[2] = '{  3,  100,  100,    1,    1,   4,  1,   3, 0, 0};
    vecs[3] = '{  1,   50,   60,   50,   61,   1,  1,   1, 1, 0};
    vecs[4] = '{  7,   10,   20,   10,   20,   3,  2,   7, 0, 1};
    vecs[5] = '{200,    5,    5,    0,    0,   0,  0,  99, 0, 0};
    vecs[6] = '{200,    5,    5,    5,    5,  99,  1,  99, 1, 1};
    vecs[7] = '{ 99, 1023, 1023, 1023,    0,  50,  1,  99, 1, 0};
    vecs[8] = '{100,    0,    0,    0,    0,  99,  1,  99, 1, 1};
    vecs[9] = '{  0,    0,    0,    1,    0,   0,  0,   0, 0, 0};

    reset  = 1'b1;
    start  = 1'b0;
    pos_x  = '0;
    pos_y  = '0;
    length = '0;
    food_x = '0;
    food_y = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_self", 32'(self_hit), 32'd0);
    chk("rst_food", 32'(food_hit), 32'd0);
    chk("rst_state", 32'(state), 32'(S_IDLE));
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset mid-scan: scan abandoned, flags cleared, no done pulse afterwards.
    fill_body();
    set_slot(0, 320, 240);
    length = 10'd50;
    food_x = 10'd320;
    food_y = 10'd240;
    start  = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_food", 32'(food_hit), 32'd1);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_food", 32'(food_hit), 32'd0);
    chk("abort_self", 32'(self_hit), 32'd0);
    chk("abort_state", 32'(state), 32'(S_IDLE));
    @(negedge clock);
    reset = 1'b0;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Start held high through a scan while live inputs change.
    fill_body();
    set_slot(0, 200, 200);
    set_slot(10, 200, 200);
    length = 10'd10;
    food_x = 10'd200;
    food_y = 10'd200;
    start  = 1'b1;
    exp_q.push_back(2'b11);
    exp_q.push_back(2'b00);
    ndone     = 0;
    first_at  = -1;
    second_at = -1;
    @(posedge clock);
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (c == 3) begin
        set_slot(10, 201, 200);
        food_x = 10'd0;
      end
      if (c == 11) chk("hold_idle_busy", 32'(busy), 32'd0);
      if (c == 12) begin
        chk("hold_reaccept", 32'(busy), 32'd1);
        start = 1'b0;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) first_at = c;
        if (ndone == 2) second_at = c;
        sb_pop($sformatf("hold%0d", ndone));
      end
    end
    chk("hold_ndone", 32'(ndone), 32'd2);
    chk("hold_first_lat", 32'(first_at), 32'd10);
    chk("hold_second_lat", 32'(second_at), 32'd22);

`ifdef SNAKE_WALL_HIT_EN
    fill_body();
    set_slot(0, 700, 10);
    length = 10'd200;
    food_x = 10'd0;
    food_y = 10'd0;
    start  = 1'b1;
    exp_q.push_back(2'b10);
    @(posedge clock);
    wait_done(99, "wall");
    chk("wall_hit", 32'(wall_hit), 32'd1);
    fill_body();
    set_slot(0, 10, 10);
    length = 10'd2;
    start  = 1'b1;
    exp_q.push_back(2'b00);
    @(posedge clock);
    wait_done(2, "nowall");
    chk("wall_clear", 32'(wall_hit), 32'd0);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
